// File: rtl/alu_serial_rx.sv
// Serial receiver for the ALU packet protocol: assembles B/A operand bytes and a control
// packet into one command record. Optional CRC4 checking is built when ALU_RX_CRC_CHECK_EN is defined.
module alu_serial_rx #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sin,
  input  logic                    cmd_ready,
  output logic                    cmd_valid,
  output logic [8*WORD_BYTES-1:0] cmd_a,
  output logic [8*WORD_BYTES-1:0] cmd_b,
  output logic [2:0]              cmd_op,
  output logic [2:0]              cmd_err,
  output logic                    overflow
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int NPKT = 2 * WORD_BYTES;
  localparam int CW   = $clog2(NPKT + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(NPKT);
  localparam logic [CW-1:0] CNT_OVER = CW'(NPKT + 1);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   pkt_cnt;
  logic            typ;
  logic [7:0]      pay;
  logic [2*W-1:0]  data_sr;

  logic            rec_done;
  logic [2:0]      rec_err;
  logic            op_bad;
  logic            crc_bad;

`ifdef ALU_RX_CRC_CHECK_EN
  logic [3:0] crc;

  // x^4+x+1, MSB first, over the low nbits of d
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic [7:0] d,
                                           input int nbits);
    logic [3:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (i < nbits) begin
        fb = r[3] ^ d[i];
        r  = {r[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= '0;
    end else if (state == S_STOP) begin
      if (!sin || typ) crc <= '0;
      else             crc <= crc4_step(crc, pay, 8);
    end
  end

  assign crc_bad = (crc4_step(crc, {4'b0000, 1'b1, pay[6:4]}, 4) != pay[3:0]);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    case (pay[6:4])
      3'b000, 3'b001, 3'b100, 3'b101: op_bad = 1'b0;
      default:                        op_bad = 1'b1;
    endcase
  end

  // A record completes at the stop bit of a CTL packet or of any packet with a bad stop bit
  always_comb begin
    rec_done = 1'b0;
    rec_err  = 3'b000;
    if (state == S_STOP) begin
      if (!sin) begin
        rec_done = 1'b1;
        rec_err  = 3'b100;
      end else if (typ) begin
        rec_done = 1'b1;
        if (pkt_cnt != CNT_FULL) rec_err = 3'b100;
        else                     rec_err = {1'b0, crc_bad, op_bad};
      end
    end
  end

  // Datapath: type, payload shifter and operand assembly
  always_ff @(posedge clk) begin
    if (state == S_TYPE)    typ <= sin;
    if (state == S_PAYLOAD) pay <= {pay[6:0], sin};
    if (state == S_STOP && sin && !typ) data_sr <= {data_sr[2*W-9:0], pay};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SYNC;
      bit_cnt   <= '0;
      pkt_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_a     <= '0;
      cmd_b     <= '0;
      cmd_op    <= '0;
      cmd_err   <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
      if (rec_done) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          cmd_a     <= data_sr[W-1:0];
          cmd_b     <= data_sr[2*W-1:W];
          cmd_op    <= pay[6:4];
          cmd_err   <= rec_err;
        end else begin
          overflow <= 1'b1;
        end
      end

      case (state)
        S_SYNC: if (sin) state <= S_IDLE;
        S_IDLE: if (!sin) state <= S_TYPE;
        S_TYPE: begin
          bit_cnt <= '0;
          state   <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_STOP;
        end
        S_STOP: begin
          if (!sin) begin
            pkt_cnt <= '0;
            state   <= S_SYNC;
          end else begin
            state <= S_IDLE;
            if (typ)                       pkt_cnt <= '0;
            else if (pkt_cnt != CNT_OVER)  pkt_cnt <= pkt_cnt + 1'b1;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: directed vector table, multi-cycle corner sequences
// and randomized frames compared against a packet-level reference model.
module tb_alu_serial_rx;

`ifdef ALU_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sin = 1'b1;
  logic        sin1 = 1'b1;
  logic        cmd_ready = 1'b1;
  logic        cmd_ready1 = 1'b1;
  logic        cmd_valid, overflow;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op, cmd_err;
  logic        cmd_valid1, overflow1;
  logic [7:0]  cmd_a1, cmd_b1;
  logic [2:0]  cmd_op1, cmd_err1;

  always #5 clk = ~clk;

  alu_serial_rx #(.WORD_BYTES(4)) u0 (
    .clk(clk), .rst(rst), .sin(sin), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_err(cmd_err), .overflow(overflow)
  );

  alu_serial_rx #(.WORD_BYTES(1)) u1 (
    .clk(clk), .rst(rst), .sin(sin1), .cmd_ready(cmd_ready1), .cmd_valid(cmd_valid1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1), .cmd_err(cmd_err1), .overflow(overflow1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } rec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    bit          flip;
    int          nd;
    logic [2:0]  err;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  rec_t q[$];
  rec_t q1[$];
  rec_t mq[$];
  logic [7:0] mb[$];
  int   qi = 0;
  int   qi1 = 0;
  int   ovf_cnt = 0;
  int   ovf1_cnt = 0;
  int   stab_err = 0;
  bit   hold_prev = 1'b0;
  rec_t held;

  // Monitor: samples mid-cycle, records accepted commands, overflow pulses and hold stability
  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!cmd_valid || cmd_a !== held.a || cmd_b !== held.b ||
                        cmd_op !== held.op || cmd_err !== held.err))
        stab_err++;
      if (overflow)  ovf_cnt++;
      if (overflow1) ovf1_cnt++;
      if (cmd_valid && cmd_ready) q.push_back('{cmd_a, cmd_b, cmd_op, cmd_err});
      if (cmd_valid1) q1.push_back('{{24'd0, cmd_a1}, {24'd0, cmd_b1}, cmd_op1, cmd_err1});
      hold_prev = cmd_valid && !cmd_ready;
      held = '{cmd_a, cmd_b, cmd_op, cmd_err};
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // CRC4 as the remainder of msg*x^4 modulo x^4+x+1 by polynomial long division
  function automatic logic [3:0] crc_bits(input logic [79:0] msg, input int nbits);
    logic [83:0] v;
    v = {msg, 4'b0000};
    for (int i = nbits + 3; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  task automatic drive_bit(input int sel, input logic b);
    @(negedge clk);
    #1;
    if (sel == 1) sin1 = b;
    else          sin  = b;
  endtask

  task automatic send_pkt(input int sel, input logic typ, input logic [7:0] pay, input logic stop);
    drive_bit(sel, 1'b0);
    drive_bit(sel, typ);
    for (int i = 7; i >= 0; i--) drive_bit(sel, pay[i]);
    drive_bit(sel, stop);
  endtask

  task automatic send_frame(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input bit flip, input int nd);
    logic [63:0] ba;
    logic [3:0]  c;
    int          nb;
    nb = (sel == 1) ? 2 : 8;
    ba = (sel == 1) ? {48'd0, b[7:0], a[7:0]} : {b, a};
    for (int j = 0; j < nd; j++)
      send_pkt(sel, 1'b0, (j < nb) ? ba[8*(nb-1-j) +: 8] : 8'hA5, 1'b1);
    c = crc_bits({12'd0, ba, 1'b1, op}, 8*nb + 4) ^ {3'b000, flip};
    send_pkt(sel, 1'b1, {1'b0, op, c}, 1'b1);
  endtask

  // Reference model: consumes the packet stream and predicts the record sequence
  task automatic model_pkt(input logic typ, input logic [7:0] pay, input logic stop);
    rec_t        r;
    logic [31:0] a, b;
    logic        opb, crcb;
    if (!stop) begin
      r = '{32'd0, 32'd0, 3'd0, 3'b100};
      mq.push_back(r);
      mb.delete();
    end else if (!typ) begin
      mb.push_back(pay);
    end else begin
      if (mb.size() != 8) begin
        r = '{32'd0, 32'd0, pay[6:4], 3'b100};
      end else begin
        b = {mb[0], mb[1], mb[2], mb[3]};
        a = {mb[4], mb[5], mb[6], mb[7]};
        opb = !(pay[6:4] == 3'd0 || pay[6:4] == 3'd1 || pay[6:4] == 3'd4 || pay[6:4] == 3'd5);
        crcb = CRC_ON && (crc_bits({12'd0, b, a, 1'b1, pay[6:4]}, 68) != pay[3:0]);
        r = '{a, b, pay[6:4], {1'b0, crcb, opb}};
      end
      mq.push_back(r);
      mb.delete();
    end
  endtask

  task automatic xmit(input logic typ, input logic [7:0] pay, input logic stop);
    send_pkt(0, typ, pay, stop);
    model_pkt(typ, pay, stop);
  endtask

  task automatic check_rec(input string tag, input logic [2:0] e_err, input logic [2:0] e_op,
                           input logic [31:0] e_a, input logic [31:0] e_b);
    rec_t r;
    chk({tag, "_count"}, 96'(q.size() - qi), 96'd1);
    if (q.size() > qi) begin
      r = q[qi];
      chk({tag, "_err"}, r.err, e_err);
      if (e_err != 3'b100) chk({tag, "_op"}, r.op, e_op);
      if (e_err == 3'b000) begin
        chk({tag, "_a"}, r.a, e_a);
        chk({tag, "_b"}, r.b, e_b);
      end
    end
    qi = q.size();
  endtask

  task automatic check_rec1(input string tag, input logic [2:0] e_err, input logic [2:0] e_op,
                            input logic [7:0] e_a, input logic [7:0] e_b);
    rec_t r;
    chk({tag, "_count"}, 96'(q1.size() - qi1), 96'd1);
    if (q1.size() > qi1) begin
      r = q1[qi1];
      chk({tag, "_err"}, r.err, e_err);
      chk({tag, "_op"}, r.op, e_op);
      if (e_err == 3'b000) begin
        chk({tag, "_a"}, r.a, {24'd0, e_a});
        chk({tag, "_b"}, r.b, {24'd0, e_b});
      end
    end
    qi1 = q1.size();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, cmd_valid, 1'b0);
    chk({tag, "_ab"}, {cmd_a, cmd_b}, 64'd0);
    chk({tag, "_op_err"}, {cmd_op, cmd_err}, 6'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
  endtask

  vec_t vt[10];

  initial begin
    int   ob;
    rec_t r;
    logic [31:0] ra, rb;
    logic [63:0] ba;
    logic [2:0]  rop;
    logic [3:0]  c;
    int   kind, nd, k, lim;
    bit   flip;

    vt[0] = '{32'h0000_0001, 32'h0000_0002, 3'b100, 1'b0, 8, 3'b000};
    vt[1] = '{32'h0000_0001, 32'h0000_0002, 3'b100, 1'b1, 8, CRC_ON ? 3'b010 : 3'b000};
    vt[2] = '{32'h0000_0001, 32'h0000_0002, 3'b011, 1'b0, 8, 3'b001};
    vt[3] = '{32'h0000_0001, 32'h0000_0002, 3'b100, 1'b0, 7, 3'b100};
    vt[4] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b100, 1'b0, 8, 3'b000};
    vt[5] = '{32'h1357_9BDF, 32'h2468_ACE0, 3'b111, 1'b1, 8, CRC_ON ? 3'b011 : 3'b001};
    vt[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 1'b0, 8, 3'b000};
    vt[7] = '{32'h0000_0000, 32'h8000_0000, 3'b101, 1'b0, 8, 3'b000};
    vt[8] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b001, 1'b0, 9, 3'b100};
    vt[9] = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 1'b0, 8, 3'b000};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    #1 rst = 1'b0;
    drive_bit(0, 1'b1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      send_frame(0, vt[i].a, vt[i].b, vt[i].op, vt[i].flip, vt[i].nd);
      if (i == 0) begin
        chk("lat_before", cmd_valid, 1'b0);
        @(negedge clk);
        chk("lat_t11", cmd_valid, 1'b1);
        @(negedge clk);
        chk("lat_after", cmd_valid, 1'b0);
      end else begin
        repeat (2) @(negedge clk);
      end
      check_rec($sformatf("vec%0d", i), vt[i].err, vt[i].op, vt[i].a, vt[i].b);
    end

    // Bad stop bit in the 3rd DATA packet, then a clean frame after resync
    send_pkt(0, 1'b0, 8'h11, 1'b1);
    send_pkt(0, 1'b0, 8'h22, 1'b1);
    send_pkt(0, 1'b0, 8'h33, 1'b0);
    drive_bit(0, 1'b1);
    repeat (2) @(negedge clk);
    check_rec("framing", 3'b100, 3'b000, 32'd0, 32'd0);
    send_frame(0, 32'hA5A5_0001, 32'h5A5A_0002, 3'b101, 1'b0, 8);
    repeat (2) @(negedge clk);
    check_rec("resync", 3'b000, 3'b101, 32'hA5A5_0001, 32'h5A5A_0002);

    // Full buffer: first record held, second dropped with one overflow pulse
    ob = ovf_cnt;
    drive_bit(0, 1'b1);
    cmd_ready = 1'b0;
    send_frame(0, 32'h1122_3344, 32'h5566_7788, 3'b000, 1'b0, 8);
    send_frame(0, 32'h99AA_BBCC, 32'hDDEE_FF00, 3'b101, 1'b0, 8);
    repeat (2) @(negedge clk);
    chk("ovf_pulses", 96'(ovf_cnt - ob), 96'd1);
    chk("hold_valid", cmd_valid, 1'b1);
    chk("hold_a", cmd_a, 32'h1122_3344);
    chk("hold_stable", 96'(stab_err), 96'd0);
    #1 cmd_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", cmd_valid, 1'b0);
    check_rec("drain", 3'b000, 3'b000, 32'h1122_3344, 32'h5566_7788);

    // Reset mid-payload with sin held low
    cmd_ready = 1'b0;
    send_frame(0, 32'h0BAD_F00D, 32'h0000_0007, 3'b100, 1'b0, 8);
    for (int j = 0; j < 3; j++) send_pkt(0, 1'b0, 8'h3C, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) drive_bit(0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (15) drive_bit(0, 1'b0);
    chk("sync_no_start", cmd_valid, 1'b0);
    cmd_ready = 1'b1;
    qi = q.size();
    drive_bit(0, 1'b1);
    send_frame(0, 32'h0000_00FE, 32'h0000_00FF, 3'b100, 1'b0, 8);
    repeat (2) @(negedge clk);
    check_rec("after_rst", 3'b000, 3'b100, 32'h0000_00FE, 32'h0000_00FF);

    // WORD_BYTES=1 instance
    send_frame(1, 32'h0000_00C3, 32'h0000_003C, 3'b100, 1'b0, 2);
    repeat (2) @(negedge clk);
    check_rec1("wb1_good", 3'b000, 3'b100, 8'hC3, 8'h3C);
    send_frame(1, 32'h0000_0081, 32'h0000_0018, 3'b001, 1'b1, 2);
    repeat (2) @(negedge clk);
    check_rec1("wb1_crc", CRC_ON ? 3'b010 : 3'b000, 3'b001, 8'h81, 8'h18);
    chk("wb1_ovf", 96'(ovf1_cnt), 96'd0);

    // Randomized frames against the reference model
    qi = q.size();
    ob = ovf_cnt;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      flip = ($urandom_range(0, 3) == 0);
      if (kind == 9) begin
        k = $urandom_range(0, 8);
        for (int j = 0; j < k; j++) xmit(1'b0, 8'($urandom), 1'b1);
        xmit(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        drive_bit(0, 1'b1);
      end else begin
        nd = (kind == 8) ? $urandom_range(0, 10) : 8;
        ba = {rb, ra};
        for (int j = 0; j < nd; j++)
          xmit(1'b0, (j < 8) ? ba[8*(7-j) +: 8] : 8'($urandom), 1'b1);
        c = crc_bits({12'd0, ba, 1'b1, rop}, 68) ^ {3'b000, flip};
        xmit(1'b1, {1'b0, rop, c}, 1'b1);
      end
      repeat ($urandom_range(0, 2)) drive_bit(0, 1'b1);
    end
    repeat (4) drive_bit(0, 1'b1);
    chk("rand_count", 96'(q.size() - qi), 96'(mq.size()));
    chk("rand_ovf", 96'(ovf_cnt - ob), 96'd0);
    lim = (q.size() - qi < mq.size()) ? q.size() - qi : mq.size();
    for (int i = 0; i < lim; i++) begin
      r = q[qi + i];
      chk($sformatf("rand%0d_err", i), r.err, mq[i].err);
      if (mq[i].err != 3'b100) chk($sformatf("rand%0d_op", i), r.op, mq[i].op);
      if (mq[i].err == 3'b000) chk($sformatf("rand%0d_ab", i), {r.a, r.b}, {mq[i].a, mq[i].b});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
